// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low code table, blank code and the
// reverse decoder used by the scan reader (the encoder can use the same table).
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Decoded view of one segment pattern.
    typedef struct packed {
        logic       illegal;
        logic       blank;
        logic [3:0] hex;
    } seg_dec_t;

    // Frame handshake state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } frame_state_t;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit.
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reverse lookup; hex is forced to 0 for blank and illegal patterns.
    function automatic seg_dec_t seg7_to_hex(input seg_t seg);
        seg_dec_t res;
        res.illegal = 1'b1;
        res.blank   = 1'b0;
        res.hex     = 4'h0;
        if (seg == SEG_BLANK) begin
            res.illegal = 1'b0;
            res.blank   = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                res.illegal = 1'b0;
                res.hex     = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_digit_tracker.sv
// Per-digit stability filter: a window sample has to repeat STABLE_SCANS
// times before it becomes the committed pattern. A one-cycle changed pulse
// marks every commit that actually alters the committed value.
module seg7_digit_tracker #(
    parameter int STABLE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       win_end,
    input  logic [6:0] sample,
    output logic [6:0] commit,
    output logic       changed
);
    import seg7_pkg::*;

    localparam logic [3:0] CNT_MAX = 4'(STABLE_SCANS);

    seg_t       cand_reg, cand_next;
    seg_t       commit_reg, commit_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       changed_reg, changed_next;

    // Candidate/count update at window ends; commit looks at the updated
    // count so a commit lands on the same edge as the deciding sample.
    always_comb begin
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        commit_next  = commit_reg;
        changed_next = 1'b0;
        if (win_end) begin
            if (sample == cand_reg) begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end else begin
                cand_next = sample;
                cnt_next  = 4'd1;
            end
        end
        // Re-stabilising on the pattern already committed is silent.
        if ((cnt_next == CNT_MAX) && (cand_next != commit_reg)) begin
            commit_next  = cand_next;
            changed_next = 1'b1;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg    <= SEG_BLANK;
            cnt_reg     <= 4'd0;
            commit_reg  <= SEG_BLANK;
            changed_reg <= 1'b0;
        end else begin
            cand_reg    <= cand_next;
            cnt_reg     <= cnt_next;
            commit_reg  <= commit_next;
            changed_reg <= changed_next;
        end
    end

    assign commit  = commit_reg;
    assign changed = changed_reg;

endmodule

// File: rtl/seg7_scan_reader.sv
// Observes a multiplexed active-low seven-segment bus, filters each digit
// for stability and hands decoded snapshots to a consumer via valid/ready.
module seg7_scan_reader #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_illegal,
    output logic                    scan_err
);
    import seg7_pkg::*;

    // Input pipeline: one capture stage plus one delay stage so that the
    // sample taken at a window end is the last value seen inside the window.
    seg_t                  r_seg, r_seg_d;
    logic [NUM_DIGITS-1:0] r_an, r_an_d;

    logic [3:0]            low_cnt;
    logic                  an_multi;
    logic [NUM_DIGITS-1:0] win_end;
    logic [NUM_DIGITS-1:0] changed;
    seg_t                  commit [NUM_DIGITS];

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_illegal;

    frame_state_t state_reg, state_next;
    logic         dirty_reg, dirty_next;
    logic         snap_en;
    logic         err_clr;
    logic         any_changed;

    logic [4*NUM_DIGITS-1:0] digits_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [NUM_DIGITS-1:0]   illegal_reg;
    logic                    scan_err_reg;

    // Two-stage capture of the display bus; idle level is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_BLANK;
            r_seg_d <= SEG_BLANK;
            r_an    <= '1;
            r_an_d  <= '1;
        end else begin
            r_seg   <= seg_n;
            r_seg_d <= r_seg;
            r_an    <= an_n;
            r_an_d  <= r_an;
        end
    end

    // More than one active enable in the delayed stage makes the cycle
    // unusable; all enables high is simply an idle gap.
    always_comb begin
        low_cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            low_cnt = low_cnt + {3'b000, ~r_an_d[i]};
        end
        an_multi = (low_cnt > 4'd1);
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            seg_dec_t dec;

            // Window closes when the delayed enable was active and the newer one is not.
            assign win_end[gi] = !an_multi && !r_an_d[gi] && r_an[gi];

            seg7_digit_tracker #(
                .STABLE_SCANS (STABLE_SCANS)
            ) u_tracker (
                .clk     (clk),
                .rst_n   (rst_n),
                .win_end (win_end[gi]),
                .sample  (r_seg_d),
                .commit  (commit[gi]),
                .changed (changed[gi])
            );

            assign dec                     = seg7_to_hex(commit[gi]);
            assign snap_digits[4*gi +: 4]  = dec.hex;
            assign snap_blank[gi]          = dec.blank;
            assign snap_illegal[gi]        = dec.illegal;
        end
    endgenerate

    assign any_changed = |changed;

    // Frame FSM: snapshot on the first change, hold while pending, and
    // re-snapshot on acceptance if anything changed in the meantime.
    always_comb begin
        state_next = state_reg;
        dirty_next = dirty_reg;
        snap_en    = 1'b0;
        err_clr    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_changed) begin
                    snap_en    = 1'b1;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (frame_ready) begin
                    err_clr = 1'b1;
                    if (dirty_reg || any_changed) begin
                        snap_en    = 1'b1;
                        dirty_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (any_changed) begin
                    dirty_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                dirty_next = 1'b0;
            end
        endcase
    end

    // FSM state and dirty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            dirty_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dirty_reg <= dirty_next;
        end
    end

    // Output snapshot registers, loaded only on a snapshot event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_reg  <= '0;
            blank_reg   <= '1;
            illegal_reg <= '0;
        end else if (snap_en) begin
            digits_reg  <= snap_digits;
            blank_reg   <= snap_blank;
            illegal_reg <= snap_illegal;
        end
    end

    // Sticky enable-collision flag; a new collision wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_err_reg <= 1'b0;
        end else if (an_multi) begin
            scan_err_reg <= 1'b1;
        end else if (err_clr) begin
            scan_err_reg <= 1'b0;
        end
    end

    assign frame_valid   = (state_reg == ST_PEND);
    assign digits        = digits_reg;
    assign digit_blank   = blank_reg;
    assign digit_illegal = illegal_reg;
    assign scan_err      = scan_err_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios followed by randomized
// scans, with expected frames queued by a behavioural model and checked by
// an independent monitor at every transfer.
module tb_seg7_scan_reader;

    localparam int ND = 4;
    localparam int SS = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic          frame_ready;
    logic          frame_valid;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_blank;
    logic [ND-1:0] digit_illegal;
    logic          scan_err;

    always #5 clk = ~clk;

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_SCANS(SS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_n         (seg_n),
        .an_n          (an_n),
        .frame_ready   (frame_ready),
        .frame_valid   (frame_valid),
        .digits        (digits),
        .digit_blank   (digit_blank),
        .digit_illegal (digit_illegal),
        .scan_err      (scan_err)
    );

    typedef struct packed {
        logic [4*ND-1:0] d;
        logic [ND-1:0]   b;
        logic [ND-1:0]   il;
    } frame_t;

    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLK = 7'b1111111;

    frame_t     exp_q[$];
    int         tests = 0;
    int         fails = 0;
    bit         rnd_ready = 0;

    // Model: committed pattern per digit, plus recent window samples.
    logic [6:0] mcommit [ND];
    logic [6:0] hist    [ND][16];
    int         nsamp   [ND];
    bit         m_idle;
    bit         m_dirty;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) frame_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic frame_t snap();
        frame_t f;
        f = '0;
        for (int k = 0; k < ND; k++) begin
            if (mcommit[k] == BLK) begin
                f.b[k] = 1'b1;
            end else begin
                f.il[k] = 1'b1;
                for (int v = 0; v < 16; v++) begin
                    if (mcommit[k] == TBL[v]) begin
                        f.il[k]      = 1'b0;
                        f.d[4*k +: 4] = 4'(v);
                    end
                end
            end
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            mcommit[k] = BLK;
            nsamp[k]   = 0;
        end
        m_idle  = 1;
        m_dirty = 0;
    endtask

    // A digit commits once its last SS window samples agree and differ
    // from what is already committed.
    task automatic model_window(input int k, input logic [6:0] s);
        bit same;
        for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = s;
        nsamp[k]++;
        same = (nsamp[k] >= SS);
        for (int i = 0; i < SS; i++) if (same && hist[k][i] != s) same = 0;
        if (same && s != mcommit[k]) begin
            mcommit[k] = s;
            if (m_idle) begin
                exp_q.push_back(snap());
                m_idle = 0;
            end else begin
                m_dirty = 1;
            end
        end
    endtask

    // One full scan, digit ND-1 first.
    task automatic do_scan(input logic [ND-1:0][6:0] pats, input bit rnd_t);
        for (int d = ND - 1; d >= 0; d--) begin
            int w;
            w = rnd_t ? int'($urandom_range(1, 3)) : 2;
            an_n    = '1;
            an_n[d] = 1'b0;
            seg_n   = pats[d];
            repeat (w) tick();
            model_window(d, pats[d]);
            if (rnd_t && $urandom_range(0, 1) == 1) begin
                an_n  = '1;
                seg_n = 7'($urandom);
                tick();
            end
        end
        an_n  = '1;
        seg_n = rnd_t ? 7'($urandom) : BLK;
        tick();
    endtask

    task automatic accept();
        if (m_dirty) begin
            exp_q.push_back(snap());
            m_dirty = 0;
        end else begin
            m_idle = 1;
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((frame_valid || exp_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting for idle, queue %0d", name, exp_q.size());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},   32'(frame_valid),   32'h0);
        chk({tag, "_digits"},  32'(digits),        32'h0);
        chk({tag, "_blank"},   32'(digit_blank),   32'hF);
        chk({tag, "_illegal"}, 32'(digit_illegal), 32'h0);
        chk({tag, "_scanerr"}, 32'(scan_err),      32'h0);
    endtask

    // Monitor: compares every transferred frame with the queue head and
    // checks that a stalled frame does not move.
    initial begin : monitor
        frame_t cur, prev_f, e;
        logic   prev_v, prev_r;
        prev_v = 0;
        prev_r = 0;
        prev_f = '0;
        forever begin
            @(negedge clk);
            cur = {digits, digit_blank, digit_illegal};
            if (rst_n) begin
                if (prev_v && !prev_r && frame_valid) chk("frozen", 32'(cur), 32'(prev_f));
                if (frame_valid && frame_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_frame: actual %0h required none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", 32'(cur), 32'(e));
                    end
                end
                prev_v = frame_valid;
                prev_r = frame_ready;
                prev_f = cur;
            end else begin
                prev_v = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [ND-1:0][6:0] p, g;
        rst_n       = 1'b0;
        frame_ready = 1'b0;
        seg_n       = BLK;
        an_n        = '1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            seg_n       = 7'($urandom);
            an_n        = ND'($urandom);
            frame_ready = 1'($urandom_range(0, 1));
            tick();
        end
        seg_n = BLK; an_n = '1; frame_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_reset_vals("reset");

        // Stable scan: 7,2,A,0. The first commit (digit 3) opens a partial
        // frame; the rest arrive while pending and are picked up on accept.
        p[3] = 7'b1111000; p[2] = 7'b0100100; p[1] = 7'b0001000; p[0] = 7'b1000000;
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        chk("stable_valid", 32'(frame_valid), 32'h1);
        repeat (5) tick();
        accept();
        chk("stable_valid2", 32'(frame_valid), 32'h1);
        chk("stable_digits", 32'(digits), 32'h72A0);

        // Glitch on digit 1 while pending: no dirty, so accept ends the frame.
        g = p; g[1] = 7'b0000000;
        do_scan(g, 0);
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        chk("glitch_digits", 32'(digits), 32'h72A0);
        accept();
        chk("glitch_valid", 32'(frame_valid), 32'h0);

        // Change during pending: digit 1 -> B opens a frame, then digit 1
        // back to A and digit 0 -> 5 while pending.
        g = p; g[1] = 7'b0000011;
        repeat (SS) do_scan(g, 0);
        repeat (4) tick();
        chk("pend_valid", 32'(frame_valid), 32'h1);
        p[0] = 7'b0010010;
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        accept();
        chk("pend_stays_valid", 32'(frame_valid), 32'h1);
        chk("pend_digits", 32'(digits), 32'h72A5);
        accept();
        tick();
        chk("pend_done", 32'(frame_valid), 32'h0);

        // Illegal digit 2 and blank digit 3.
        p[3] = BLK; p[2] = 7'b0110110;
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        accept();
        chk("illegal_flags", 32'(digit_illegal), 32'h4);
        chk("blank_flags",   32'(digit_blank),   32'h8);
        chk("illegal_nib",   32'(digits[11:8]),  32'h0);
        accept();

        // Enable collision: sticky error and no commits.
        an_n = 4'b1100; seg_n = 7'b1111001;
        repeat (2) tick();
        an_n = '1; seg_n = BLK;
        repeat (4) tick();
        chk("err_set",      32'(scan_err),    32'h1);
        chk("err_no_frame", 32'(frame_valid), 32'h0);
        p[0] = 7'b0110000;
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        chk("err_sticky", 32'(scan_err), 32'h1);
        accept();
        chk("err_clear", 32'(scan_err),    32'h0);
        chk("err_idle",  32'(frame_valid), 32'h0);

        // Asynchronous reset in PEND with the error flag set.
        an_n = 4'b0101;
        repeat (2) tick();
        an_n = '1;
        p[0] = 7'b0011001;
        repeat (SS) do_scan(p, 0);
        repeat (4) tick();
        chk("rst_pre_valid", 32'(frame_valid), 32'h1);
        chk("rst_pre_err",   32'(scan_err),    32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        exp_q.delete();
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // Randomized: one digit change per round, random window timing,
        // garbage in gaps, occasional glitch scans, random ready.
        for (int k = 0; k < ND; k++) p[k] = BLK;
        rnd_ready = 1;
        for (int it = 0; it < 40; it++) begin
            int k, j, sel;
            logic [6:0] np;
            wait_idle("rand_idle");
            m_idle  = 1;
            m_dirty = 0;
            k   = int'($urandom_range(0, ND - 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      np = TBL[$urandom_range(0, 15)];
            else if (sel < 7) np = BLK;
            else              np = 7'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                g = p;
                j = int'($urandom_range(0, ND - 1));
                g[j] = 7'($urandom);
                do_scan(g, 1);
            end
            p[k] = np;
            repeat (SS) do_scan(p, 1);
            repeat (4) tick();
        end
        wait_idle("rand_drain");
        rnd_ready   = 0;
        frame_ready = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
